// File: rtl/jtframe_scan2x_core_pkg.sv
// Purpose : shared defaults and address-width helper for the scan doubler.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
// Contents: default pixel width and line length, and scan2x_aw(), which picks
//           the line-buffer address width from the line length.
package jtframe_scan2x_core_pkg;

  localparam int SCAN2X_DW_DEF   = 12;
  localparam int SCAN2X_HLEN_DEF = 384;

  // Line buffers are addressed by pixel index, so the width only has to cover HLEN.
  function automatic int scan2x_aw(input int hlen);
    if (hlen <= 256)      return 8;
    else if (hlen <= 512) return 9;
    else                  return 10;
  endfunction

endpackage

// File: rtl/jtframe_dual_ram.sv
// Purpose : one line bank, a single write port and a single asynchronous read port.
// Latency : write lands on the clk edge with i_we; read data is combinational.
// Backpressure: none; the caller gates writes with its clock enable.
// Ports   : i_clk; i_we, i_waddr, i_wdata (write port); i_raddr, o_rdata (read port).
module jtframe_dual_ram #(
  parameter int DW    = 12,
  parameter int AW    = 9,
  parameter int DEPTH = 384
)(
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/jtframe_scan2x_core.sv
// Purpose : line doubler; stores each 15 kHz line and replays it twice at 2x pixel rate.
// Latency : one basex2_cen from read address to x2_pxl; a line appears during the next input line.
// Backpressure: none; free-running on clock enables, every register holds when no cen is active.
// Ports   : clk, rst (sync, active high); base_cen/basex2_cen pixel enables;
//           base_pxl, HS (input video); x2_pxl, x2_HS (doubled video, registered).
module jtframe_scan2x_core
  import jtframe_scan2x_core_pkg::*;
#(
  parameter int DW   = SCAN2X_DW_DEF,
  parameter int HLEN = SCAN2X_HLEN_DEF
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          base_cen,
  input  logic          basex2_cen,
  input  logic [DW-1:0] base_pxl,
  input  logic          HS,
  output logic [DW-1:0] x2_pxl,
  output logic          x2_HS
);

  localparam int            AW   = scan2x_aw(HLEN);
  localparam logic [AW-1:0] LAST = AW'(HLEN - 1);

  logic          r_last_hs;
  logic [AW-1:0] r_wraddr;
  logic [AW-1:0] r_rdaddr;
  logic          r_bank;
  logic [AW-1:0] r_hs_len;
  logic [AW-1:0] r_hs_cnt;
  logic          r_wait_hs;
  logic [DW-1:0] r_x2_pxl;
  logic          r_x2_hs;

  logic          w_hs_rise;
  logic          w_hs_fall;
  logic          w_we0;
  logic          w_we1;
  logic [DW-1:0] w_rd0;
  logic [DW-1:0] w_rd1;
  logic [DW-1:0] w_rd_pxl;

  assign w_hs_rise = base_cen &  HS & ~r_last_hs;
  assign w_hs_fall = base_cen & ~HS &  r_last_hs;

  // Write goes to the active bank, read comes from the other one (the previous line).
  assign w_we0    = base_cen & ~r_bank;
  assign w_we1    = base_cen &  r_bank;
  assign w_rd_pxl = r_bank ? w_rd0 : w_rd1;

  jtframe_dual_ram #(.DW(DW), .AW(AW), .DEPTH(HLEN)) u_mem0 (
    .i_clk   (clk),
    .i_we    (w_we0),
    .i_waddr (r_wraddr),
    .i_wdata (base_pxl),
    .i_raddr (r_rdaddr),
    .o_rdata (w_rd0)
  );

  jtframe_dual_ram #(.DW(DW), .AW(AW), .DEPTH(HLEN)) u_mem1 (
    .i_clk   (clk),
    .i_we    (w_we1),
    .i_waddr (r_wraddr),
    .i_wdata (base_pxl),
    .i_raddr (r_rdaddr),
    .o_rdata (w_rd1)
  );

  // Input side: line write address, bank swap and HS width measurement.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_hs <= 1'b0;
      r_wraddr  <= '0;
      r_bank    <= 1'b0;
      r_hs_len  <= '0;
      r_hs_cnt  <= '0;
      r_wait_hs <= 1'b1;
    end else if (base_cen) begin
      r_last_hs <= HS;
      if (w_hs_rise) begin
        // The pixel on the rising edge still closes the old line (written above
        // with the old bank/address); the new line starts on the next tick.
        r_wraddr  <= '0;
        r_bank    <= ~r_bank;
        r_hs_cnt  <= {{(AW-1){1'b0}}, 1'b1};
        r_wait_hs <= 1'b0;
      end else begin
        // Overlong lines keep overwriting the final entry instead of wrapping.
        if (r_wraddr != LAST) r_wraddr <= r_wraddr + 1'b1;
        if (HS && r_hs_cnt != LAST) r_hs_cnt <= r_hs_cnt + 1'b1;
      end
      if (w_hs_fall) r_hs_len <= r_hs_cnt;
    end
  end

  // Output side: replay address and registered outputs at double rate.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdaddr <= '0;
      r_x2_pxl <= '0;
      r_x2_hs  <= 1'b0;
    end else if (basex2_cen) begin
      // A new input line always restarts the replay, even mid-pass (short lines).
      if (w_hs_rise)             r_rdaddr <= '0;
      else if (r_rdaddr == LAST) r_rdaddr <= '0;
      else                       r_rdaddr <= r_rdaddr + 1'b1;
      r_x2_pxl <= r_wait_hs ? '0 : w_rd_pxl;
      r_x2_hs  <= ~r_wait_hs & (r_rdaddr < r_hs_len);
    end
  end

  assign x2_pxl = r_x2_pxl;
  assign x2_HS  = r_x2_hs;

endmodule

// File: tb/tb_jtframe_scan2x_core.sv
// Purpose : directed bench for the line doubler (ramp, bank swap, short/long lines, reset).
// Latency : captures every basex2_cen output sample per input line and checks it afterwards.
// Backpressure: n/a; the bench drives both clock enables itself.
module tb_jtframe_scan2x_core;

  logic        clk;
  logic        rst;
  logic        base_cen;
  logic        basex2_cen;
  logic [11:0] base_pxl;
  logic        HS;
  logic [11:0] x2_pxl;
  logic        x2_HS;

  int total;
  int bad;

  logic [11:0] cap_pxl [0:1023];
  logic        cap_hs  [0:1023];
  logic [11:0] prev_last;
  logic [11:0] rst_obs_pxl;
  logic        rst_obs_hs;

  jtframe_scan2x_core #(.DW(12), .HLEN(384)) dut (
    .clk        (clk),
    .rst        (rst),
    .base_cen   (base_cen),
    .basex2_cen (basex2_cen),
    .base_pxl   (base_pxl),
    .HS         (HS),
    .x2_pxl     (x2_pxl),
    .x2_HS      (x2_HS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input logic b, input logic b2);
    base_cen   = b;
    basex2_cen = b2;
    @(posedge clk);
    #1;
  endtask

  // One input line of len base ticks. Tick 0 carries the HS rising edge and the
  // last pixel of the previous line; ticks 1..len-1 carry pixels 0..len-2.
  // Output samples of each x2 tick land in cap_*[0..2*len-1].
  task automatic send_line(input int len, input int hsw, input bit ramp,
                           input logic [11:0] val, input int rst_at);
    logic [11:0] p;
    for (int t = 0; t < len; t++) begin
      if (t == rst_at) begin
        rst = 1'b1;
        cyc(1'b0, 1'b0);
        rst = 1'b0;
        rst_obs_pxl = x2_pxl;
        rst_obs_hs  = x2_HS;
      end
      HS = (t < hsw);
      if (t == 0) p = prev_last;
      else if (ramp) p = 12'(t - 1);
      else p = val;
      base_pxl = p;
      cyc(1'b1, 1'b1);
      cap_pxl[2*t] = x2_pxl;
      cap_hs[2*t]  = x2_HS;
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b1);
      cap_pxl[2*t+1] = x2_pxl;
      cap_hs[2*t+1]  = x2_HS;
      cyc(1'b0, 1'b0);
    end
    prev_last = ramp ? 12'(len - 1) : val;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    HS = 1'b0;
    base_pxl = 12'hABC;
    prev_last = 12'hABC;
    repeat (4) cyc(1'b0, 1'b0);
    rst = 1'b0;
    cyc(1'b0, 1'b0);
    total++;
    if (x2_pxl !== 12'h000) begin
      bad++; $display("FAIL reset_pxl got=%h exp=000", x2_pxl);
    end
    total++;
    if (x2_HS !== 1'b0) begin
      bad++; $display("FAIL reset_hs got=%b exp=0", x2_HS);
    end
    // Idle with pixels but no HS edge: output must stay blank.
    send_line(20, 0, 1'b0, 12'hABC, -1);
    for (int j = 0; j < 40; j++) begin
      total++;
      if (cap_pxl[j] !== 12'h000 || cap_hs[j] !== 1'b0) begin
        bad++; $display("FAIL idle_blank j=%0d got=%h/%b exp=000/0", j, cap_pxl[j], cap_hs[j]);
      end
    end
  endtask

  task automatic test_ramp;
    send_line(384, 36, 1'b1, 12'h000, -1);        // ramp line 0..383
    send_line(384, 36, 1'b0, 12'h0F0, -1);        // line A, replays the ramp
    for (int j = 1; j < 768; j++) begin
      logic [11:0] e;
      logic        eh;
      e  = 12'((j - 1) % 384);
      eh = ((j - 1) % 384) < 36;
      total++;
      if (cap_pxl[j] !== e) begin
        bad++; $display("FAIL ramp_pxl j=%0d got=%h exp=%h", j, cap_pxl[j], e);
      end
      total++;
      if (cap_hs[j] !== eh) begin
        bad++; $display("FAIL ramp_hs j=%0d got=%b exp=%b", j, cap_hs[j], eh);
      end
    end
  endtask

  task automatic test_bank_alt;
    send_line(384, 36, 1'b0, 12'h00F, -1);        // line B, shows A twice
    for (int j = 1; j < 768; j++) begin
      total++;
      if (cap_pxl[j] !== 12'h0F0) begin
        bad++; $display("FAIL bank_a j=%0d got=%h exp=0f0", j, cap_pxl[j]);
      end
    end
    send_line(384, 36, 1'b0, 12'h555, -1);        // shows B twice
    for (int j = 1; j < 768; j++) begin
      total++;
      if (cap_pxl[j] !== 12'h00F) begin
        bad++; $display("FAIL bank_b j=%0d got=%h exp=00f", j, cap_pxl[j]);
      end
    end
  endtask

  task automatic test_short;
    send_line(300, 36, 1'b0, 12'h123, -1);        // short line, replays 555
    for (int j = 1; j < 600; j++) begin
      logic eh;
      eh = ((j - 1) % 384) < 36;
      total++;
      if (cap_pxl[j] !== 12'h555 || cap_hs[j] !== eh) begin
        bad++; $display("FAIL short_run j=%0d got=%h/%b exp=555/%b", j, cap_pxl[j], cap_hs[j], eh);
      end
    end
    send_line(384, 36, 1'b0, 12'h456, -1);
    // Rising edge sample still shows the old bank at rdaddr 215.
    total++;
    if (cap_pxl[0] !== 12'h555) begin
      bad++; $display("FAIL short_edge got=%h exp=555", cap_pxl[0]);
    end
    // Short line fills entries 0..299; 300..383 keep line B from two lines back.
    for (int j = 1; j < 768; j++) begin
      logic [11:0] e;
      logic        eh;
      e  = (((j - 1) % 384) < 300) ? 12'h123 : 12'h00F;
      eh = ((j - 1) % 384) < 36;
      total++;
      if (cap_pxl[j] !== e || cap_hs[j] !== eh) begin
        bad++; $display("FAIL short_replay j=%0d got=%h/%b exp=%h/%b", j, cap_pxl[j], cap_hs[j], e, eh);
      end
    end
  endtask

  task automatic test_long;
    send_line(400, 36, 1'b1, 12'h000, -1);        // 400-pixel ramp
    for (int j = 1; j < 800; j++) begin
      total++;
      if (cap_pxl[j] !== 12'h456) begin
        bad++; $display("FAIL long_run j=%0d got=%h exp=456", j, cap_pxl[j]);
      end
    end
    send_line(384, 36, 1'b0, 12'hA5A, -1);
    for (int j = 1; j < 768; j++) begin
      int          r;
      logic [11:0] e;
      r = (j - 1) % 384;
      e = (r == 383) ? 12'd399 : 12'(r);
      total++;
      if (cap_pxl[j] !== e) begin
        bad++; $display("FAIL long_replay j=%0d got=%h exp=%h", j, cap_pxl[j], e);
      end
    end
  endtask

  task automatic test_midreset;
    send_line(384, 36, 1'b0, 12'h777, 100);       // reset before tick 100
    total++;
    if (cap_pxl[199] !== 12'hA5A) begin
      bad++; $display("FAIL pre_reset got=%h exp=a5a", cap_pxl[199]);
    end
    total++;
    if (rst_obs_pxl !== 12'h000 || rst_obs_hs !== 1'b0) begin
      bad++; $display("FAIL reset_now got=%h/%b exp=000/0", rst_obs_pxl, rst_obs_hs);
    end
    for (int j = 200; j < 768; j++) begin
      total++;
      if (cap_pxl[j] !== 12'h000 || cap_hs[j] !== 1'b0) begin
        bad++; $display("FAIL reset_blank j=%0d got=%h/%b exp=000/0", j, cap_pxl[j], cap_hs[j]);
      end
    end
    send_line(384, 36, 1'b0, 12'h888, -1);
    total++;
    if (cap_pxl[0] !== 12'h000 || cap_hs[0] !== 1'b0) begin
      bad++; $display("FAIL resume_edge got=%h/%b exp=000/0", cap_pxl[0], cap_hs[0]);
    end
    // Entries 0..284 rewritten after reset; the rest still hold A5A. HS width is
    // unknown until this line's HS falls, so only the second half carries a pulse.
    for (int j = 1; j < 768; j++) begin
      int          r;
      logic [11:0] e;
      logic        eh;
      r  = (j - 1) % 384;
      e  = (r <= 284) ? 12'h777 : 12'hA5A;
      eh = (j >= 385) && (r < 36);
      total++;
      if (cap_pxl[j] !== e || cap_hs[j] !== eh) begin
        bad++; $display("FAIL resume j=%0d got=%h/%b exp=%h/%b", j, cap_pxl[j], cap_hs[j], e, eh);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    base_cen = 1'b0;
    basex2_cen = 1'b0;
    base_pxl = '0;
    HS = 1'b0;
    prev_last = '0;
    rst_obs_pxl = '0;
    rst_obs_hs = 1'b0;
    test_reset();
    test_ramp();
    test_bank_alt();
    test_short();
    test_long();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
